ri_sdram_seq: RTL and testbench

- DDR SDRAM command sequencer sitting directly upstream of the RI pad stage.
- Converts single-burst client requests (burst of 4 × 32-bit beats = two 64-bit words) into active-high command/address/data-enable strobes (mcs/mras/mcas/mwe/mcke/mdqm/maddr/mbank/mdout/mdout_ena/mdin_ena); the pad stage inverts and DDR-launches them.
- Owns power-up init, periodic auto-refresh and closed-page access (every access uses auto-precharge).

---
 rtl/ri_sdram_seq.sv | 283 ++++++++++++++++++++++++++++
 tb/tb_ri_sdram_seq.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ri_sdram_seq.sv
// rtl/ri_sdram_seq.sv - DDR SDRAM command sequencer: power-up init, auto-refresh, closed-page burst access
module ri_sdram_seq #(
  parameter int          INIT_WAIT    = 200,
  parameter int          T_RP         = 2,
  parameter int          T_RCD        = 2,
  parameter int          T_WR         = 2,
  parameter int          T_RFC        = 8,
  parameter int          REF_INTERVAL = 780,
  parameter int          RD_DELAY     = 3,
  parameter logic [12:0] MODE_VALUE   = 13'h0022
) (
  input  logic        memclk,
  input  logic        reset,
  input  logic        req,
  input  logic        req_write,
  input  logic [23:0] req_addr,
  output logic        req_ack,
  input  logic [63:0] wdata,
  output logic        wdata_ack,
  output logic [63:0] rdata,
  output logic        rdata_valid,
  output logic        init_done,
  output logic        mcs,
  output logic        mras,
  output logic        mcas,
  output logic        mwe,
  output logic        mcke,
  output logic [7:0]  mdqm,
  output logic [12:0] maddr,
  output logic [1:0]  mbank,
  output logic [63:0] mdout,
  output logic        mdout_ena,
  input  logic [63:0] mdin,
  output logic        mdin_ena
);

  localparam int CW = 16;

  // {mcs, mras, mcas, mwe}, active high; the pad stage inverts
  localparam logic [3:0] CMD_NOP   = 4'b1000;
  localparam logic [3:0] CMD_ACT   = 4'b1100;
  localparam logic [3:0] CMD_READ  = 4'b1010;
  localparam logic [3:0] CMD_WRITE = 4'b1011;
  localparam logic [3:0] CMD_PRE   = 4'b1101;
  localparam logic [3:0] CMD_REF   = 4'b1110;
  localparam logic [3:0] CMD_MRS   = 4'b1111;

  typedef enum logic [3:0] {
    ST_INIT_WAIT,
    ST_INIT_PRE,
    ST_INIT_REF1,
    ST_INIT_REF2,
    ST_INIT_MRS,
    ST_IDLE,
    ST_REF,
    ST_RCD,
    ST_RECOV
  } state_t;

  state_t          r_state, w_state_n;
  logic [CW-1:0]   r_cnt, w_cnt_n;
  logic            w_cnt_zero;

  logic [CW-1:0]   r_ref_cnt;
  logic            r_ref_pending;

  logic [1:0]      r_bank;
  logic [6:0]      r_col;
  logic            r_write;

  logic [3:0]      w_cmd;
  logic [12:0]     w_maddr;
  logic [1:0]      w_mbank;
  logic            w_req_ack;
  logic            w_init_set;
  logic            w_ref_clr;
  logic            w_col_wr;
  logic            w_col_rd;
  logic            w_wr_beat;
  logic            w_rd_beat;

  logic [3:0]      r_cmd;
  logic [12:0]     r_maddr;
  logic [1:0]      r_mbank;
  logic            r_req_ack;
  logic            r_init_done;
  logic            r_mcke;
  logic            r_wbeat;
  logic            r_rbeat;
  logic            r_mdout_ena;
  logic            r_wdata_ack;
  logic [63:0]     r_mdout;
  logic [7:0]      r_mdqm;

  logic [RD_DELAY-1:0] r_rd_sr;
  logic            r_mdin_ena;
  logic            r_rdata_valid;
  logic [63:0]     r_rdata;

  // Burst is always 4 beats aligned, so the low column bits carry nothing
  logic            w_unused_addr;
  assign w_unused_addr = ^req_addr[1:0];

  assign w_cnt_zero = (r_cnt == '0);
  assign w_wr_beat  = w_col_wr | r_wbeat;
  assign w_rd_beat  = w_col_rd | r_rbeat;

  // State and wait-counter register
  always_ff @(posedge memclk or posedge reset) begin
    if (reset) begin
      r_state <= ST_INIT_WAIT;
      r_cnt   <= CW'(INIT_WAIT);
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
    end
  end

  // Next state; counter loads give the number of NOP cycles before the state acts again
  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = w_cnt_zero ? r_cnt : r_cnt - 1'b1;
    case (r_state)
      ST_INIT_WAIT: if (w_cnt_zero) begin w_state_n = ST_INIT_PRE;  w_cnt_n = CW'(T_RP);  end
      ST_INIT_PRE:  if (w_cnt_zero) begin w_state_n = ST_INIT_REF1; w_cnt_n = CW'(T_RFC); end
      ST_INIT_REF1: if (w_cnt_zero) begin w_state_n = ST_INIT_REF2; w_cnt_n = CW'(T_RFC); end
      ST_INIT_REF2: if (w_cnt_zero) begin w_state_n = ST_INIT_MRS;  w_cnt_n = CW'(2);     end
      ST_INIT_MRS:  if (w_cnt_zero) w_state_n = ST_IDLE;
      ST_IDLE: begin
        if (r_ref_pending) begin
          w_state_n = ST_REF;
          w_cnt_n   = CW'(T_RFC - 1);
        end else if (req) begin
          w_state_n = ST_RCD;
          w_cnt_n   = CW'(T_RCD - 1);
        end
      end
      ST_REF:   if (w_cnt_zero) w_state_n = ST_IDLE;
      // Recovery covers both data beats plus write recovery / auto-precharge
      ST_RCD: if (w_cnt_zero) begin
        w_state_n = ST_RECOV;
        w_cnt_n   = r_write ? CW'(T_WR + T_RP) : CW'(T_RP);
      end
      ST_RECOV: if (w_cnt_zero) w_state_n = ST_IDLE;
      default: begin
        w_state_n = ST_INIT_WAIT;
        w_cnt_n   = CW'(INIT_WAIT);
      end
    endcase
  end

  // Command, address and side-effect strobes for the coming cycle
  always_comb begin
    w_cmd      = CMD_NOP;
    w_maddr    = '0;
    w_mbank    = '0;
    w_req_ack  = 1'b0;
    w_init_set = 1'b0;
    w_ref_clr  = 1'b0;
    w_col_wr   = 1'b0;
    w_col_rd   = 1'b0;
    case (r_state)
      ST_INIT_WAIT: if (w_cnt_zero) begin w_cmd = CMD_PRE; w_maddr = 13'h0400; end
      ST_INIT_PRE:  if (w_cnt_zero) w_cmd = CMD_REF;
      ST_INIT_REF1: if (w_cnt_zero) w_cmd = CMD_REF;
      ST_INIT_REF2: if (w_cnt_zero) begin w_cmd = CMD_MRS; w_maddr = MODE_VALUE; end
      ST_INIT_MRS:  if (w_cnt_zero) w_init_set = 1'b1;
      ST_IDLE: begin
        if (r_ref_pending) begin
          w_cmd     = CMD_REF;
          w_ref_clr = 1'b1;
        end else if (req) begin
          w_cmd     = CMD_ACT;
          w_maddr   = req_addr[21:9];
          w_mbank   = req_addr[23:22];
          w_req_ack = 1'b1;
        end
      end
      ST_RCD: if (w_cnt_zero) begin
        w_cmd    = r_write ? CMD_WRITE : CMD_READ;
        w_maddr  = {2'b00, 1'b1, 1'b0, r_col, 2'b00};
        w_mbank  = r_bank;
        w_col_wr = r_write;
        w_col_rd = ~r_write;
      end
      default: ;
    endcase
  end

  // Latch the request at ACT so the column command does not depend on req_* afterwards
  always_ff @(posedge memclk or posedge reset) begin
    if (reset) begin
      r_bank  <= '0;
      r_col   <= '0;
      r_write <= 1'b0;
    end else if (w_req_ack) begin
      r_bank  <= req_addr[23:22];
      r_col   <= req_addr[8:2];
      r_write <= req_write;
    end
  end

  // Refresh timer: one pending flag, so a second expiry before service collapses into it
  always_ff @(posedge memclk or posedge reset) begin
    if (reset) begin
      r_ref_cnt     <= CW'(REF_INTERVAL);
      r_ref_pending <= 1'b0;
    end else begin
      if (r_init_done) begin
        if (r_ref_cnt == '0) r_ref_cnt <= CW'(REF_INTERVAL);
        else                 r_ref_cnt <= r_ref_cnt - 1'b1;
      end
      if (w_ref_clr)
        r_ref_pending <= 1'b0;
      else if (r_init_done && r_ref_cnt == '0)
        r_ref_pending <= 1'b1;
    end
  end

  // Registered pad-facing outputs; the write beats follow the WRITE command directly
  always_ff @(posedge memclk or posedge reset) begin
    if (reset) begin
      r_cmd       <= 4'b0000;
      r_maddr     <= '0;
      r_mbank     <= '0;
      r_req_ack   <= 1'b0;
      r_init_done <= 1'b0;
      r_mcke      <= 1'b0;
      r_wbeat     <= 1'b0;
      r_rbeat     <= 1'b0;
      r_mdout_ena <= 1'b0;
      r_wdata_ack <= 1'b0;
      r_mdout     <= '0;
      r_mdqm      <= 8'hFF;
    end else begin
      r_cmd       <= w_cmd;
      r_maddr     <= w_maddr;
      r_mbank     <= w_mbank;
      r_req_ack   <= w_req_ack;
      r_mcke      <= 1'b1;
      if (w_init_set) r_init_done <= 1'b1;
      r_wbeat     <= w_col_wr;
      r_rbeat     <= w_col_rd;
      r_mdout_ena <= w_wr_beat;
      r_wdata_ack <= w_wr_beat;
      if (w_wr_beat) r_mdout <= wdata;
      r_mdqm      <= (w_wr_beat | w_rd_beat) ? 8'h00 : 8'hFF;
    end
  end

  // Read return pipe: shift register so overlapping reads never lose a beat
  always_ff @(posedge memclk or posedge reset) begin
    if (reset) begin
      r_rd_sr       <= '0;
      r_mdin_ena    <= 1'b0;
      r_rdata_valid <= 1'b0;
      r_rdata       <= '0;
    end else begin
      r_rd_sr       <= (r_rd_sr << 1) | RD_DELAY'(w_rd_beat);
      r_mdin_ena    <= r_rd_sr[RD_DELAY-1];
      r_rdata_valid <= r_mdin_ena;
      if (r_mdin_ena) r_rdata <= mdin;
    end
  end

  assign mcs         = r_cmd[3];
  assign mras        = r_cmd[2];
  assign mcas        = r_cmd[1];
  assign mwe         = r_cmd[0];
  assign mcke        = r_mcke;
  assign mdqm        = r_mdqm;
  assign maddr       = r_maddr;
  assign mbank       = r_mbank;
  assign mdout       = r_mdout;
  assign mdout_ena   = r_mdout_ena;
  assign mdin_ena    = r_mdin_ena;
  assign req_ack     = r_req_ack;
  assign wdata_ack   = r_wdata_ack;
  assign rdata       = r_rdata;
  assign rdata_valid = r_rdata_valid;
  assign init_done   = r_init_done;

endmodule

// File: tb/tb_ri_sdram_seq.sv
// tb/tb_ri_sdram_seq.sv - directed self-checking bench for ri_sdram_seq
module tb_ri_sdram_seq;

  logic        memclk = 1'b0;
  logic        reset = 1'b1;
  logic        req = 1'b0;
  logic        req_write = 1'b0;
  logic [23:0] req_addr = '0;
  logic        req_ack;
  logic [63:0] wdata = '0;
  logic        wdata_ack;
  logic [63:0] rdata;
  logic        rdata_valid;
  logic        init_done;
  logic        mcs, mras, mcas, mwe, mcke;
  logic [7:0]  mdqm;
  logic [12:0] maddr;
  logic [1:0]  mbank;
  logic [63:0] mdout;
  logic        mdout_ena;
  logic [63:0] mdin = '0;
  logic        mdin_ena;

  localparam logic [3:0] C_NOP   = 4'b1000;
  localparam logic [3:0] C_ACT   = 4'b1100;
  localparam logic [3:0] C_READ  = 4'b1010;
  localparam logic [3:0] C_WRITE = 4'b1011;
  localparam logic [3:0] C_PRE   = 4'b1101;
  localparam logic [3:0] C_REF   = 4'b1110;
  localparam logic [3:0] C_MRS   = 4'b1111;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [3:0] cmd;
  assign cmd = {mcs, mras, mcas, mwe};

  ri_sdram_seq dut (
    .memclk(memclk), .reset(reset), .req(req), .req_write(req_write), .req_addr(req_addr),
    .req_ack(req_ack), .wdata(wdata), .wdata_ack(wdata_ack), .rdata(rdata),
    .rdata_valid(rdata_valid), .init_done(init_done), .mcs(mcs), .mras(mras), .mcas(mcas),
    .mwe(mwe), .mcke(mcke), .mdqm(mdqm), .maddr(maddr), .mbank(mbank), .mdout(mdout),
    .mdout_ena(mdout_ena), .mdin(mdin), .mdin_ena(mdin_ena)
  );

  always #5 memclk = ~memclk;

  // cycle k = the cycle after the k-th rising edge since reset release
  always @(posedge memclk or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  task automatic test_reset();
    checks++; if (mcke !== 1'b0) begin failures++; $display("FAIL reset_mcke got %b exp 0", mcke); end
    checks++; if (cmd !== 4'b0000) begin failures++; $display("FAIL reset_cmd got %b exp 0000", cmd); end
    checks++; if (mdqm !== 8'hFF) begin failures++; $display("FAIL reset_mdqm got %h exp ff", mdqm); end
    checks++; if (init_done !== 1'b0) begin failures++; $display("FAIL reset_init_done got %b exp 0", init_done); end
    checks++; if ({req_ack, wdata_ack, mdout_ena, mdin_ena, rdata_valid} !== 5'b0) begin
      failures++; $display("FAIL reset_strobes got %b exp 00000", {req_ack, wdata_ack, mdout_ena, mdin_ena, rdata_valid});
    end
  endtask

  task automatic test_init(input string tag);
    int t_cke, t_pre, t_ref1, t_ref2, t_mrs, t_done, n_other;
    logic [12:0] a_pre, a_mrs;
    logic [1:0]  b_mrs;
    t_cke = -1; t_pre = -1; t_ref1 = -1; t_ref2 = -1; t_mrs = -1; t_done = -1; n_other = 0;
    a_pre = '0; a_mrs = '0; b_mrs = 2'b11;
    while (init_done !== 1'b1 && cyc < 400) begin
      @(negedge memclk);
      if (t_cke < 0 && mcke === 1'b1) t_cke = cyc;
      case (cmd)
        C_NOP: ;
        C_PRE: if (t_pre < 0) begin t_pre = cyc; a_pre = maddr; end else n_other++;
        C_REF: if (t_ref1 < 0) t_ref1 = cyc; else if (t_ref2 < 0) t_ref2 = cyc; else n_other++;
        C_MRS: if (t_mrs < 0) begin t_mrs = cyc; a_mrs = maddr; b_mrs = mbank; end else n_other++;
        default: if (cyc > 0) n_other++;
      endcase
      if (init_done === 1'b1) t_done = cyc;
    end
    checks++; if (t_cke != 1) begin failures++; $display("FAIL %s_mcke_cycle got %0d exp 1", tag, t_cke); end
    checks++; if (t_pre != 201) begin failures++; $display("FAIL %s_pre_cycle got %0d exp 201", tag, t_pre); end
    checks++; if (a_pre[10] !== 1'b1) begin failures++; $display("FAIL %s_pre_a10 got %b exp 1", tag, a_pre[10]); end
    checks++; if (t_ref1 != 204) begin failures++; $display("FAIL %s_ref1_cycle got %0d exp 204", tag, t_ref1); end
    checks++; if (t_ref2 != 213) begin failures++; $display("FAIL %s_ref2_cycle got %0d exp 213", tag, t_ref2); end
    checks++; if (t_mrs != 222) begin failures++; $display("FAIL %s_mrs_cycle got %0d exp 222", tag, t_mrs); end
    checks++; if (a_mrs !== 13'h0022) begin failures++; $display("FAIL %s_mrs_addr got %h exp 0022", tag, a_mrs); end
    checks++; if (b_mrs !== 2'b00) begin failures++; $display("FAIL %s_mrs_bank got %0d exp 0", tag, b_mrs); end
    checks++; if (t_done != 225) begin failures++; $display("FAIL %s_init_done_cycle got %0d exp 225", tag, t_done); end
    checks++; if (n_other != 0) begin failures++; $display("FAIL %s_extra_cmds got %0d exp 0", tag, n_other); end
  endtask

  task automatic test_write();
    int t_act, t_w, t_d0, t_d1, n_ack, n_reqack;
    logic [3:0]  act_cmd;
    logic [12:0] act_addr, w_addr;
    logic [1:0]  act_bank, w_bank;
    logic [63:0] d0, d1;
    logic [7:0]  dqm_w, dqm_after;
    logic        ena_mismatch;
    t_act = -1; t_w = -1; t_d0 = -1; t_d1 = -1; n_ack = 0; n_reqack = 0;
    act_cmd = '0; act_addr = '0; w_addr = '0; act_bank = '0; w_bank = '0;
    d0 = '0; d1 = '0; dqm_w = 8'h5A; dqm_after = 8'h5A; ena_mismatch = 1'b0;
    wdata = 64'h0123_4567_89AB_CDEF; req_write = 1'b1; req_addr = 24'h41_2345; req = 1'b1;
    for (int i = 0; i < 40 && t_act < 0; i++) begin
      @(negedge memclk);
      if (req_ack === 1'b1) begin t_act = cyc; act_cmd = cmd; act_addr = maddr; act_bank = mbank; n_reqack++; end
    end
    req = 1'b0;
    for (int i = 0; i < 14; i++) begin
      @(negedge memclk);
      if (req_ack === 1'b1) n_reqack++;
      if (cmd === C_WRITE && t_w < 0) begin t_w = cyc; w_addr = maddr; w_bank = mbank; end
      if (mdout_ena !== wdata_ack) ena_mismatch = 1'b1;
      if (wdata_ack === 1'b1) begin
        if (n_ack == 0) begin t_d0 = cyc; d0 = mdout; dqm_w = mdqm; wdata = 64'hFEDC_BA98_7654_3210; end
        else if (n_ack == 1) begin t_d1 = cyc; d1 = mdout; end
        n_ack++;
      end
      if (t_w >= 0 && cyc == t_w + 2) dqm_after = mdqm;
    end
    checks++; if (t_act < 0) begin failures++; $display("FAIL wr_ack_timeout got none exp req_ack within 40 cycles"); end
    checks++; if (act_cmd !== C_ACT) begin failures++; $display("FAIL wr_act_cmd got %b exp %b", act_cmd, C_ACT); end
    checks++; if (act_bank !== 2'd1) begin failures++; $display("FAIL wr_act_bank got %0d exp 1", act_bank); end
    checks++; if (act_addr !== 13'h0091) begin failures++; $display("FAIL wr_act_row got %h exp 0091", act_addr); end
    checks++; if (t_w != t_act + 2) begin failures++; $display("FAIL wr_cmd_cycle got %0d exp %0d", t_w, t_act + 2); end
    checks++; if (w_addr !== 13'h0544) begin failures++; $display("FAIL wr_col_addr got %h exp 0544", w_addr); end
    checks++; if (w_bank !== 2'd1) begin failures++; $display("FAIL wr_col_bank got %0d exp 1", w_bank); end
    checks++; if (n_ack != 2) begin failures++; $display("FAIL wr_ack_count got %0d exp 2", n_ack); end
    checks++; if (t_d0 != t_w) begin failures++; $display("FAIL wr_beat0_cycle got %0d exp %0d", t_d0, t_w); end
    checks++; if (t_d1 != t_w + 1) begin failures++; $display("FAIL wr_beat1_cycle got %0d exp %0d", t_d1, t_w + 1); end
    checks++; if (d0 !== 64'h0123_4567_89AB_CDEF) begin failures++; $display("FAIL wr_word0 got %h exp 0123456789abcdef", d0); end
    checks++; if (d1 !== 64'hFEDC_BA98_7654_3210) begin failures++; $display("FAIL wr_word1 got %h exp fedcba9876543210", d1); end
    checks++; if (dqm_w !== 8'h00) begin failures++; $display("FAIL wr_dqm_active got %h exp 00", dqm_w); end
    checks++; if (dqm_after !== 8'hFF) begin failures++; $display("FAIL wr_dqm_after got %h exp ff", dqm_after); end
    checks++; if (ena_mismatch !== 1'b0) begin failures++; $display("FAIL wr_ena_vs_ack got mismatch exp equal"); end
    checks++; if (n_reqack != 1) begin failures++; $display("FAIL wr_req_ack_count got %0d exp 1", n_reqack); end
  endtask

  task automatic test_read();
    int t_act, t_r, n_e, n_v;
    int t_e[2];
    int t_v[2];
    logic [63:0] v[2];
    logic [63:0] dv[2];
    logic [12:0] r_addr;
    logic [7:0]  dqm_r, dqm_r1, dqm_r2;
    t_act = -1; t_r = -1; n_e = 0; n_v = 0;
    t_e[0] = -1; t_e[1] = -1; t_v[0] = -1; t_v[1] = -1; v[0] = '0; v[1] = '0;
    dv[0] = 64'hA5A5_0000_1111_2222; dv[1] = 64'h5A5A_3333_4444_5555;
    r_addr = '0; dqm_r = 8'h5A; dqm_r1 = 8'h5A; dqm_r2 = 8'h5A;
    req_write = 1'b0; req_addr = 24'h41_2345; req = 1'b1;
    for (int i = 0; i < 40 && t_act < 0; i++) begin
      @(negedge memclk);
      if (req_ack === 1'b1) t_act = cyc;
    end
    req = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge memclk);
      if (cmd === C_READ && t_r < 0) begin t_r = cyc; r_addr = maddr; dqm_r = mdqm; end
      if (t_r >= 0 && cyc == t_r + 1) dqm_r1 = mdqm;
      if (t_r >= 0 && cyc == t_r + 2) dqm_r2 = mdqm;
      if (rdata_valid === 1'b1) begin
        if (n_v < 2) begin t_v[n_v] = cyc; v[n_v] = rdata; end
        n_v++;
      end
      if (mdin_ena === 1'b1) begin
        if (n_e < 2) begin t_e[n_e] = cyc; mdin = dv[n_e]; end
        n_e++;
      end else begin
        mdin = 64'hBAD0_BAD0_BAD0_BAD0;
      end
    end
    checks++; if (t_act < 0) begin failures++; $display("FAIL rd_ack_timeout got none exp req_ack within 40 cycles"); end
    checks++; if (t_r != t_act + 2) begin failures++; $display("FAIL rd_cmd_cycle got %0d exp %0d", t_r, t_act + 2); end
    checks++; if (r_addr !== 13'h0544) begin failures++; $display("FAIL rd_col_addr got %h exp 0544", r_addr); end
    checks++; if (dqm_r !== 8'h00 || dqm_r1 !== 8'h00) begin failures++; $display("FAIL rd_dqm_active got %h/%h exp 00/00", dqm_r, dqm_r1); end
    checks++; if (dqm_r2 !== 8'hFF) begin failures++; $display("FAIL rd_dqm_after got %h exp ff", dqm_r2); end
    checks++; if (n_e != 2) begin failures++; $display("FAIL rd_mdin_ena_count got %0d exp 2", n_e); end
    checks++; if (t_e[0] != t_r + 3 || t_e[1] != t_r + 4) begin
      failures++; $display("FAIL rd_mdin_ena_cycles got %0d,%0d exp %0d,%0d", t_e[0], t_e[1], t_r + 3, t_r + 4);
    end
    checks++; if (n_v != 2) begin failures++; $display("FAIL rd_valid_count got %0d exp 2", n_v); end
    checks++; if (t_v[0] != t_r + 4 || t_v[1] != t_r + 5) begin
      failures++; $display("FAIL rd_valid_cycles got %0d,%0d exp %0d,%0d", t_v[0], t_v[1], t_r + 4, t_r + 5);
    end
    checks++; if (v[0] !== dv[0]) begin failures++; $display("FAIL rd_word0 got %h exp %h", v[0], dv[0]); end
    checks++; if (v[1] !== dv[1]) begin failures++; $display("FAIL rd_word1 got %h exp %h", v[1], dv[1]); end
  endtask

  task automatic test_back_to_back();
    int t_a1, t_a2, t_r1, t_r2, n_ack, n_rd, n_e, n_v, bad_data;
    logic [63:0] ev[4];
    logic [12:0] a2_row;
    logic [1:0]  a2_bank;
    t_a1 = -1; t_a2 = -1; t_r1 = -1; t_r2 = -1; n_ack = 0; n_rd = 0; n_e = 0; n_v = 0; bad_data = 0;
    a2_row = '0; a2_bank = '0;
    ev[0] = 64'h1111_1111_1111_1111; ev[1] = 64'h2222_2222_2222_2222;
    ev[2] = 64'h3333_3333_3333_3333; ev[3] = 64'h4444_4444_4444_4444;
    req_write = 1'b0; req_addr = 24'h80_1234; req = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge memclk);
      if (req_ack === 1'b1) begin
        if (n_ack == 0) t_a1 = cyc;
        else if (n_ack == 1) begin t_a2 = cyc; a2_row = maddr; a2_bank = mbank; end
        n_ack++;
        if (n_ack == 1) req_addr = 24'hC0_0F0C;
        if (n_ack >= 2) req = 1'b0;
      end
      if (cmd === C_READ) begin
        if (n_rd == 0) t_r1 = cyc; else if (n_rd == 1) t_r2 = cyc;
        n_rd++;
      end
      if (rdata_valid === 1'b1) begin
        if (n_v < 4 && rdata !== ev[n_v]) bad_data++;
        n_v++;
      end
      if (mdin_ena === 1'b1) begin
        if (n_e < 4) mdin = ev[n_e];
        n_e++;
      end else begin
        mdin = 64'hBAD1_BAD1_BAD1_BAD1;
      end
    end
    req = 1'b0;
    checks++; if (n_ack != 2) begin failures++; $display("FAIL b2b_ack_count got %0d exp 2", n_ack); end
    checks++; if (t_r1 != t_a1 + 2) begin failures++; $display("FAIL b2b_read1_cycle got %0d exp %0d", t_r1, t_a1 + 2); end
    checks++; if (t_a2 != t_r1 + 4) begin failures++; $display("FAIL b2b_act2_cycle got %0d exp %0d", t_a2, t_r1 + 4); end
    checks++; if (t_r2 != t_a2 + 2) begin failures++; $display("FAIL b2b_read2_cycle got %0d exp %0d", t_r2, t_a2 + 2); end
    checks++; if (a2_bank !== 2'd3 || a2_row !== 13'h0007) begin
      failures++; $display("FAIL b2b_act2_addr got bank %0d row %h exp bank 3 row 0007", a2_bank, a2_row);
    end
    checks++; if (n_e != 4) begin failures++; $display("FAIL b2b_mdin_ena_count got %0d exp 4", n_e); end
    checks++; if (n_v != 4) begin failures++; $display("FAIL b2b_valid_count got %0d exp 4", n_v); end
    checks++; if (bad_data != 0) begin failures++; $display("FAIL b2b_data got %0d bad words exp 0", bad_data); end
  endtask

  // init_done at 225, counter runs from edge 226: 780 decrements reach 0, pending seen in cycle 1006
  task automatic test_refresh_vs_req();
    int t_ref, t_act, n_ack, n_ref;
    t_ref = -1; t_act = -1; n_ack = 0; n_ref = 0;
    while (cyc < 1006) @(negedge memclk);
    req_write = 1'b0; req_addr = 24'h00_0200; req = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge memclk);
      if (cmd === C_REF) begin if (t_ref < 0) t_ref = cyc; n_ref++; end
      if (cmd === C_ACT && t_act < 0) t_act = cyc;
      if (req_ack === 1'b1) begin n_ack++; req = 1'b0; end
    end
    req = 1'b0;
    checks++; if (t_ref != 1007) begin failures++; $display("FAIL ref_cycle got %0d exp 1007", t_ref); end
    checks++; if (n_ref != 1) begin failures++; $display("FAIL ref_count got %0d exp 1", n_ref); end
    checks++; if (t_act < 0 || t_act < t_ref + 8) begin
      failures++; $display("FAIL ref_act_spacing got act %0d ref %0d exp act >= ref+8", t_act, t_ref);
    end
    checks++; if (n_ack != 1) begin failures++; $display("FAIL ref_req_ack_count got %0d exp 1", n_ack); end
  endtask

  task automatic test_reset_midwrite();
    int seen;
    seen = 0;
    wdata = 64'hCAFE_F00D_CAFE_F00D; req_write = 1'b1; req_addr = 24'h40_0008; req = 1'b1;
    for (int i = 0; i < 40 && seen == 0; i++) begin
      @(negedge memclk);
      if (req_ack === 1'b1) req = 1'b0;
      if (wdata_ack === 1'b1) seen = 1;
    end
    req = 1'b0;
    checks++; if (seen != 1) begin failures++; $display("FAIL rst_mid_reach_write got %0d exp 1", seen); end
    #2;
    reset = 1'b1;
    #1;
    checks++; if (mcke !== 1'b0) begin failures++; $display("FAIL rst_mid_mcke got %b exp 0", mcke); end
    checks++; if (cmd !== 4'b0000) begin failures++; $display("FAIL rst_mid_cmd got %b exp 0000", cmd); end
    checks++; if ({mdout_ena, wdata_ack} !== 2'b00) begin failures++; $display("FAIL rst_mid_data got %b exp 00", {mdout_ena, wdata_ack}); end
    checks++; if (init_done !== 1'b0) begin failures++; $display("FAIL rst_mid_init_done got %b exp 0", init_done); end
    checks++; if (mdqm !== 8'hFF) begin failures++; $display("FAIL rst_mid_mdqm got %h exp ff", mdqm); end
    repeat (3) @(negedge memclk);
    reset = 1'b0;
    test_init("reinit");
  endtask

  initial begin
    reset = 1'b1;
    repeat (3) @(negedge memclk);
    test_reset();
    reset = 1'b0;
    test_init("init");
    test_write();
    test_read();
    test_back_to_back();
    test_refresh_vs_req();
    test_reset_midwrite();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
